// File: rtl/pdh_pkg.sv
// Shared definitions for the DAC write sequencer: FSM states, the mid-scale
// reset code and the channel-mask encodings.
package pdh_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP1,
        WRT1,
        SETUP2,
        WRT2
    } seq_state_e;

    localparam logic [13:0] MID_CODE_DEFAULT = 14'h2000;

    localparam logic [1:0] CH1  = 2'b01;
    localparam logic [1:0] CH2  = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;

    function automatic logic has_chan(input logic [1:0] mask, input logic [1:0] chan);
        return (mask & chan) != 2'b00;
    endfunction

endpackage

// File: rtl/dac_write_sequencer_if.sv
// Request handshake plus the interleaved DAC bus of the write sequencer.
interface dac_write_sequencer_if #(
    parameter int DAC_DATA_WIDTH = 14
);
    logic                      req_valid_i;
    logic                      req_ready_o;
    logic [1:0]                req_chan_i;
    logic [DAC_DATA_WIDTH-1:0] req_ch1_i;
    logic [DAC_DATA_WIDTH-1:0] req_ch2_i;

    logic [DAC_DATA_WIDTH-1:0] dac_dat_o;
    logic                      dac_wrt_o;
    logic                      dac_sel_o;
    logic                      dac_rst_o;

    modport master (
        output req_valid_i, req_chan_i, req_ch1_i, req_ch2_i,
        input  req_ready_o, dac_dat_o, dac_wrt_o, dac_sel_o, dac_rst_o
    );

    modport slave (
        input  req_valid_i, req_chan_i, req_ch1_i, req_ch2_i,
        output req_ready_o, dac_dat_o, dac_wrt_o, dac_sel_o, dac_rst_o
    );
endinterface

// File: rtl/dac_write_sequencer.sv
// Sequences one- or two-channel writes onto an interleaved DAC bus: a setup
// cycle with the strobe low, then HOLD_CYCLES cycles with the strobe high.
module dac_write_sequencer
    import pdh_pkg::*;
#(
    parameter int                        DAC_DATA_WIDTH = 14,
    parameter logic [DAC_DATA_WIDTH-1:0] MID_CODE       = DAC_DATA_WIDTH'(MID_CODE_DEFAULT),
    parameter int                        HOLD_CYCLES    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    dac_write_sequencer_if.slave      bus,
    output logic                      busy_o,
    output logic [DAC_DATA_WIDTH-1:0] ch1_cur_o,
    output logic [DAC_DATA_WIDTH-1:0] ch2_cur_o,
    output logic [15:0]               write_count_o
);

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    seq_state_e                state, state_nxt;
    logic [DAC_DATA_WIDTH-1:0] ch1_lat, ch1_lat_nxt;
    logic [DAC_DATA_WIDTH-1:0] ch2_lat, ch2_lat_nxt;
    logic                      ch2_pend, ch2_pend_nxt;
    logic [3:0]                hold_cnt, hold_cnt_nxt;
    logic [DAC_DATA_WIDTH-1:0] ch1_cur_nxt, ch2_cur_nxt;
    logic [15:0]               count_nxt;
    logic [DAC_DATA_WIDTH-1:0] dat_nxt;
    logic                      sel_nxt, wrt_nxt;
    logic                      accept, hold_done;

    assign bus.req_ready_o = (state == IDLE) && !rst;
    assign bus.dac_rst_o   = rst;
    assign busy_o          = (state != IDLE);
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign hold_done       = (hold_cnt == HOLD_LAST);

    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        ch1_lat_nxt  = ch1_lat;
        ch2_lat_nxt  = ch2_lat;
        ch2_pend_nxt = ch2_pend;
        hold_cnt_nxt = hold_cnt;
        ch1_cur_nxt  = ch1_cur_o;
        ch2_cur_nxt  = ch2_cur_o;
        count_nxt    = write_count_o;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (has_chan(bus.req_chan_i, CH1)) ch1_lat_nxt = bus.req_ch1_i;
                    if (has_chan(bus.req_chan_i, CH2)) ch2_lat_nxt = bus.req_ch2_i;
                    ch2_pend_nxt = has_chan(bus.req_chan_i, CH2);
                    if (has_chan(bus.req_chan_i, CH1))      state_nxt = SETUP1;
                    else if (has_chan(bus.req_chan_i, CH2)) state_nxt = SETUP2;
                end
            end
            SETUP1: state_nxt = WRT1;
            WRT1: begin
                if (hold_done) begin
                    hold_cnt_nxt = 4'd0;
                    ch1_cur_nxt  = ch1_lat;
                    count_nxt    = write_count_o + 16'd1;
                    state_nxt    = ch2_pend ? SETUP2 : IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            SETUP2: state_nxt = WRT2;
            WRT2: begin
                if (hold_done) begin
                    hold_cnt_nxt = 4'd0;
                    ch2_cur_nxt  = ch2_lat;
                    count_nxt    = write_count_o + 16'd1;
                    state_nxt    = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus values are decoded from the next state so the registered outputs line up with it.
    always_comb begin
        dat_nxt = ch1_cur_nxt;
        sel_nxt = 1'b0;
        wrt_nxt = 1'b0;
        case (state_nxt)
            SETUP1, WRT1: begin
                dat_nxt = ch1_lat_nxt;
                wrt_nxt = (state_nxt == WRT1);
            end
            SETUP2, WRT2: begin
                dat_nxt = ch2_lat_nxt;
                sel_nxt = 1'b1;
                wrt_nxt = (state_nxt == WRT2);
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ch1_lat       <= MID_CODE;
            ch2_lat       <= MID_CODE;
            ch2_pend      <= 1'b0;
            hold_cnt      <= 4'd0;
            ch1_cur_o     <= MID_CODE;
            ch2_cur_o     <= MID_CODE;
            write_count_o <= 16'd0;
            bus.dac_dat_o <= MID_CODE;
            bus.dac_sel_o <= 1'b0;
            bus.dac_wrt_o <= 1'b0;
        end else begin
            state         <= state_nxt;
            ch1_lat       <= ch1_lat_nxt;
            ch2_lat       <= ch2_lat_nxt;
            ch2_pend      <= ch2_pend_nxt;
            hold_cnt      <= hold_cnt_nxt;
            ch1_cur_o     <= ch1_cur_nxt;
            ch2_cur_o     <= ch2_cur_nxt;
            write_count_o <= count_nxt;
            bus.dac_dat_o <= dat_nxt;
            bus.dac_sel_o <= sel_nxt;
            bus.dac_wrt_o <= wrt_nxt;
        end
    end

endmodule

// File: tb/tb_dac_write_sequencer.sv
// Directed bench for dac_write_sequencer: one instance with HOLD_CYCLES=1 and
// one with HOLD_CYCLES=3 for the hold-length and counter-wrap cases.
module tb_dac_write_sequencer;
    import pdh_pkg::*;

    localparam int W = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dac_write_sequencer_if #(.DAC_DATA_WIDTH(W)) bus  ();
    dac_write_sequencer_if #(.DAC_DATA_WIDTH(W)) bus3 ();

    logic         busy, busy3;
    logic [W-1:0] ch1_cur, ch2_cur, ch1_cur3, ch2_cur3;
    logic [15:0]  cnt, cnt3;

    dac_write_sequencer #(.DAC_DATA_WIDTH(W), .HOLD_CYCLES(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .busy_o        (busy),
        .ch1_cur_o     (ch1_cur),
        .ch2_cur_o     (ch2_cur),
        .write_count_o (cnt)
    );

    dac_write_sequencer #(.DAC_DATA_WIDTH(W), .HOLD_CYCLES(3)) dut3 (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus3.slave),
        .busy_o        (busy3),
        .ch1_cur_o     (ch1_cur3),
        .ch2_cur_o     (ch2_cur3),
        .write_count_o (cnt3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_chk(input string tag, input logic [W-1:0] d, input logic s, input logic w);
        check({tag, ".dat"}, 32'(bus.dac_dat_o), 32'(d));
        check({tag, ".sel"}, 32'(bus.dac_sel_o), 32'(s));
        check({tag, ".wrt"}, 32'(bus.dac_wrt_o), 32'(w));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [1:0] chan, input logic [W-1:0] c1, input logic [W-1:0] c2);
        bus.req_valid_i = 1'b1;
        bus.req_chan_i  = chan;
        bus.req_ch1_i   = c1;
        bus.req_ch2_i   = c2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_chan_i   = 2'b00;
        bus.req_ch1_i    = '0;
        bus.req_ch2_i    = '0;
        bus3.req_valid_i = 1'b0;
        bus3.req_chan_i  = 2'b00;
        bus3.req_ch1_i   = '0;
        bus3.req_ch2_i   = '0;
        rst = 1'b1;

        // Reset state
        step();
        step();
        bus_chk("rst", 14'h2000, 1'b0, 1'b0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.ready", 32'(bus.req_ready_o), 32'd0);
        check("rst.ch1_cur", 32'(ch1_cur), 32'h2000);
        check("rst.ch2_cur", 32'(ch2_cur), 32'h2000);
        check("rst.count", 32'(cnt), 32'd0);
        check("rst.dac_rst", 32'(bus.dac_rst_o), 32'd1);
        check("rst.dac_rst3", 32'(bus3.dac_rst_o), 32'd1);
        rst = 1'b0;
        step();
        check("rel.ready", 32'(bus.req_ready_o), 32'd1);
        check("rel.dac_rst", 32'(bus.dac_rst_o), 32'd0);

        // Reset pulse in the middle of WRT1 aborts the write
        request(CH1, 14'h1234, 14'h0000);
        step();
        bus.req_valid_i = 1'b0;
        bus_chk("abort.setup1", 14'h1234, 1'b0, 1'b0);
        check("abort.busy", 32'(busy), 32'd1);
        step();
        bus_chk("abort.wrt1", 14'h1234, 1'b0, 1'b1);
        #3 rst = 1'b1;
        #1;
        bus_chk("abort.async", 14'h2000, 1'b0, 1'b0);
        check("abort.count", 32'(cnt), 32'd0);
        check("abort.ready_in_rst", 32'(bus.req_ready_o), 32'd0);
        check("abort.busy_in_rst", 32'(busy), 32'd0);
        #2 rst = 1'b0;
        step();
        check("abort.ready_after", 32'(bus.req_ready_o), 32'd1);
        check("abort.ch1_cur", 32'(ch1_cur), 32'h2000);
        check("abort.count_after", 32'(cnt), 32'd0);

        // Both channels, HOLD_CYCLES=1: latency and bus sequence
        request(BOTH, 14'h1000, 14'h3000);
        step();
        bus.req_valid_i = 1'b0;
        bus_chk("both.c1", 14'h1000, 1'b0, 1'b0);
        check("both.c1.ready", 32'(bus.req_ready_o), 32'd0);
        step();
        bus_chk("both.c2", 14'h1000, 1'b0, 1'b1);
        step();
        bus_chk("both.c3", 14'h3000, 1'b1, 1'b0);
        check("both.c3.count", 32'(cnt), 32'd1);
        step();
        bus_chk("both.c4", 14'h3000, 1'b1, 1'b1);
        check("both.c4.ready", 32'(bus.req_ready_o), 32'd0);
        step();
        check("both.c5.ready", 32'(bus.req_ready_o), 32'd1);
        check("both.c5.busy", 32'(busy), 32'd0);
        check("both.count", 32'(cnt), 32'd2);
        check("both.ch1_cur", 32'(ch1_cur), 32'h1000);
        check("both.ch2_cur", 32'(ch2_cur), 32'h3000);
        bus_chk("both.idle", 14'h1000, 1'b0, 1'b0);

        // Reset while idle restores mid-scale and clears the counter
        rst = 1'b1;
        #1;
        check("idle_rst.count", 32'(cnt), 32'd0);
        check("idle_rst.ch1_cur", 32'(ch1_cur), 32'h2000);
        check("idle_rst.dat", 32'(bus.dac_dat_o), 32'h2000);
        #3 rst = 1'b0;
        step();

        // ch2 only: unmasked ch1 input is not latched
        request(CH2, 14'h1555, 14'h0ABC);
        step();
        bus.req_valid_i = 1'b0;
        bus_chk("ch2.setup", 14'h0ABC, 1'b1, 1'b0);
        step();
        bus_chk("ch2.wrt", 14'h0ABC, 1'b1, 1'b1);
        step();
        bus_chk("ch2.idle", 14'h2000, 1'b0, 1'b0);
        check("ch2.ch1_cur", 32'(ch1_cur), 32'h2000);
        check("ch2.ch2_cur", 32'(ch2_cur), 32'h0ABC);
        check("ch2.count", 32'(cnt), 32'd1);

        // Empty mask: consumed with no DAC activity
        request(2'b00, 14'h0FFF, 14'h0FFF);
        step();
        bus.req_valid_i = 1'b0;
        check("none.ready", 32'(bus.req_ready_o), 32'd1);
        check("none.busy", 32'(busy), 32'd0);
        bus_chk("none.bus", 14'h2000, 1'b0, 1'b0);
        step();
        check("none.wrt_next", 32'(bus.dac_wrt_o), 32'd0);
        check("none.count", 32'(cnt), 32'd1);

        // Request arriving while busy waits for ready, then runs in order
        request(CH1, 14'h0111, 14'h0EEE);
        step();
        request(BOTH, 14'h0222, 14'h0333);
        bus_chk("q.a_setup", 14'h0111, 1'b0, 1'b0);
        step();
        bus_chk("q.a_wrt", 14'h0111, 1'b0, 1'b1);
        check("q.a_busy", 32'(busy), 32'd1);
        step();
        check("q.idle_ready", 32'(bus.req_ready_o), 32'd1);
        bus_chk("q.idle", 14'h0111, 1'b0, 1'b0);
        check("q.a_count", 32'(cnt), 32'd2);
        check("q.a_ch1_cur", 32'(ch1_cur), 32'h0111);
        step();
        bus.req_valid_i = 1'b0;
        bus_chk("q.b_setup1", 14'h0222, 1'b0, 1'b0);
        step();
        bus_chk("q.b_wrt1", 14'h0222, 1'b0, 1'b1);
        step();
        bus_chk("q.b_setup2", 14'h0333, 1'b1, 1'b0);
        step();
        bus_chk("q.b_wrt2", 14'h0333, 1'b1, 1'b1);
        step();
        check("q.b_count", 32'(cnt), 32'd4);
        check("q.b_ch1_cur", 32'(ch1_cur), 32'h0222);
        check("q.b_ch2_cur", 32'(ch2_cur), 32'h0333);
        bus_chk("q.b_idle", 14'h0222, 1'b0, 1'b0);

        // HOLD_CYCLES=3 instance: counter wrap and strobe length
        force dut3.write_count_o = 16'hFFFF;
        #1;
        release dut3.write_count_o;
        bus3.req_valid_i = 1'b1;
        bus3.req_chan_i  = CH1;
        bus3.req_ch1_i   = 14'h0F0F;
        bus3.req_ch2_i   = 14'h1111;
        step();
        bus3.req_valid_i = 1'b0;
        check("h3.setup.wrt", 32'(bus3.dac_wrt_o), 32'd0);
        check("h3.setup.dat", 32'(bus3.dac_dat_o), 32'h0F0F);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("h3.wrt%0d.wrt", i), 32'(bus3.dac_wrt_o), 32'd1);
            check($sformatf("h3.wrt%0d.dat", i), 32'(bus3.dac_dat_o), 32'h0F0F);
            check($sformatf("h3.wrt%0d.busy", i), 32'(busy3), 32'd1);
            check($sformatf("h3.wrt%0d.count", i), 32'(cnt3), 32'hFFFF);
        end
        step();
        check("h3.end.wrt", 32'(bus3.dac_wrt_o), 32'd0);
        check("h3.end.sel", 32'(bus3.dac_sel_o), 32'd0);
        check("h3.end.count_wrap", 32'(cnt3), 32'h0000);
        check("h3.end.ch1_cur", 32'(ch1_cur3), 32'h0F0F);
        check("h3.end.ch2_cur", 32'(ch2_cur3), 32'h2000);
        check("h3.end.ready", 32'(bus3.req_ready_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
